// File: rtl/led_frame_arbiter.sv
// led_frame_arbiter
// Two writers share a 4x8 LED frame plus a 3-bit brightness setting.
// Writes go to a shadow copy; the shadow is copied to the live registers
// (which feed the LED matrix driver) only on frame_tick, so a frame is
// never displayed half-updated.
//
// Ports:
//   clk12MHz            system clock, rising edge
//   rst                 synchronous active-high reset
//   frame_tick          one-cycle frame boundary pulse (commit shadow -> live)
//   reqN_valid/addr/data  write request from requester N (N = 0,1)
//                       addr 0..3 column, 4 brightness, 5..7 invalid
//   reqN_ready          combinational grant; accept = valid && ready
//   leds1..leds4        live columns
//   leds_pwm            live brightness
//   pending             a shadow write has not yet been committed
//   bad_addr            one-cycle pulse after an accepted write to addr 5..7
module led_frame_arbiter #(
    parameter logic [2:0] PWM_RESET = 3'd7,
    parameter int         COL_COUNT = 4
) (
    input  logic       clk12MHz,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       req0_valid,
    input  logic [2:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [7:0] leds1,
    output logic [7:0] leds2,
    output logic [7:0] leds3,
    output logic [7:0] leds4,
    output logic [2:0] leds_pwm,
    output logic       pending,
    output logic       bad_addr
);

    typedef struct packed {
        logic       valid;
        logic [2:0] addr;
        logic [7:0] data;
    } wr_req_t;

    localparam logic [2:0] PWM_ADDR = 3'd4;

    logic                        rr_ptr;
    logic [COL_COUNT-1:0][7:0]   shadow_col;
    logic [COL_COUNT-1:0][7:0]   live_col;
    logic [2:0]                  shadow_pwm;
    logic [2:0]                  live_pwm;

    wr_req_t wr;
    logic    wr_good;     // accepted write to a real register (0..4)
    logic    wr_bad;      // accepted write to 5..7

    // Grant: a lone requester always wins; on contention rr_ptr picks.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                req0_ready = (rr_ptr == 1'b0);
                req1_ready = (rr_ptr == 1'b1);
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    // Mux the single accepted write for this cycle.
    always_comb begin
        wr = '0;
        if (req0_valid && req0_ready) begin
            wr = '{valid: 1'b1, addr: req0_addr, data: req0_data};
        end else if (req1_valid && req1_ready) begin
            wr = '{valid: 1'b1, addr: req1_addr, data: req1_data};
        end
    end

    assign wr_good = wr.valid && (wr.addr <= PWM_ADDR);
    assign wr_bad  = wr.valid && (wr.addr >  PWM_ADDR);

    // Column storage. The live copy takes the pre-edge shadow value, so a
    // write landing in a tick cycle waits for the following tick.
    for (genvar c = 0; c < COL_COUNT; c++) begin : g_col
        always_ff @(posedge clk12MHz) begin
            if (rst) begin
                shadow_col[c] <= 8'h00;
                live_col[c]   <= 8'h00;
            end else begin
                if (wr_good && (wr.addr == 3'(c)))
                    shadow_col[c] <= wr.data;
                if (frame_tick)
                    live_col[c] <= shadow_col[c];
            end
        end
    end

    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            shadow_pwm <= PWM_RESET;
            live_pwm   <= PWM_RESET;
            rr_ptr     <= 1'b0;
            pending    <= 1'b0;
            bad_addr   <= 1'b0;
        end else begin
            if (wr_good && (wr.addr == PWM_ADDR))
                shadow_pwm <= wr.data[2:0];
            if (frame_tick)
                live_pwm <= shadow_pwm;
            // The winner yields priority to the other requester next time.
            if (req0_valid && req0_ready)
                rr_ptr <= 1'b1;
            else if (req1_valid && req1_ready)
                rr_ptr <= 1'b0;
            // A same-cycle write survives the commit's clear.
            pending  <= (pending && !frame_tick) || wr_good;
            bad_addr <= wr_bad;
        end
    end

    assign leds1    = live_col[0];
    assign leds2    = live_col[1];
    assign leds3    = live_col[2];
    assign leds4    = live_col[3];
    assign leds_pwm = live_pwm;

endmodule

// File: tb/tb_led_frame_arbiter.sv
module tb_led_frame_arbiter;

    logic       clk12MHz = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [2:0] req0_addr = '0, req1_addr = '0;
    logic [7:0] req0_data = '0, req1_data = '0;
    logic       req0_ready, req1_ready;
    logic [7:0] leds1, leds2, leds3, leds4;
    logic [2:0] leds_pwm;
    logic       pending, bad_addr;

    led_frame_arbiter #(.PWM_RESET(3'd7), .COL_COUNT(4)) dut (
        .clk12MHz(clk12MHz), .rst(rst), .frame_tick(frame_tick),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .leds1(leds1), .leds2(leds2), .leds3(leds3), .leds4(leds4),
        .leds_pwm(leds_pwm), .pending(pending), .bad_addr(bad_addr)
    );

    always #5 clk12MHz = ~clk12MHz;

    typedef struct packed {
        logic [2:0] a;
        logic [7:0] d;
    } wr_t;

    // Each writer holds the head of its queue on the bus until accepted.
    wr_t q0[$];
    wr_t q1[$];

    // Reference model: plain arrays of what the memory must hold.
    int  m_shadow[4];
    int  m_live[4];
    int  m_spwm, m_lpwm;
    int  m_next;       // requester that wins a contested cycle
    bit  m_pend, m_bad;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  last_grant;   // -1 none, else requester index accepted by DUT

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 0;
            m_live[i]   = 0;
        end
        m_spwm = 7; m_lpwm = 7; m_next = 0; m_pend = 0; m_bad = 0;
    endtask

    // One clock: drive, check grants, let the edge happen, update model, check state.
    task automatic step(input bit rs, input bit tk);
        int  g;
        int  a, d;
        bit  r0s, r1s, e0, e1;
        int  snap[4];
        @(negedge clk12MHz);
        rst = rs;
        frame_tick = tk;
        req0_valid = (q0.size() > 0);
        req1_valid = (q1.size() > 0);
        if (req0_valid) begin req0_addr = q0[0].a; req0_data = q0[0].d; end
        else begin req0_addr = 3'($urandom); req0_data = 8'($urandom); end
        if (req1_valid) begin req1_addr = q1[0].a; req1_data = q1[0].d; end
        else begin req1_addr = 3'($urandom); req1_data = 8'($urandom); end
        #1;
        e0 = 0; e1 = 0;
        if (!rs) begin
            if (req0_valid && req1_valid) begin e0 = (m_next == 0); e1 = (m_next == 1); end
            else begin e0 = req0_valid; e1 = req1_valid; end
        end
        chk("req0_ready", int'(req0_ready), int'(e0));
        chk("req1_ready", int'(req1_ready), int'(e1));
        r0s = req0_valid && req0_ready;
        r1s = req1_valid && req1_ready;
        @(posedge clk12MHz);
        // model update from the model's own grant decision
        g = e0 ? 0 : (e1 ? 1 : -1);
        if (rs) model_reset();
        else begin
            snap = m_shadow;
            m_bad = 0;
            if (tk) begin
                m_live = snap;
                m_lpwm = m_spwm;
                m_pend = 0;
            end
            if (g >= 0) begin
                a = (g == 0) ? int'(req0_addr) : int'(req1_addr);
                d = (g == 0) ? int'(req0_data) : int'(req1_data);
                if (a < 4) m_shadow[a] = d;
                else if (a == 4) m_spwm = d % 8;
                if (a <= 4) m_pend = 1;
                else m_bad = 1;
                m_next = 1 - g;
            end
        end
        last_grant = r0s ? 0 : (r1s ? 1 : -1);
        if (r0s) void'(q0.pop_front());
        if (r1s) void'(q1.pop_front());
        #1;
        chk("leds1", int'(leds1), m_live[0]);
        chk("leds2", int'(leds2), m_live[1]);
        chk("leds3", int'(leds3), m_live[2]);
        chk("leds4", int'(leds4), m_live[3]);
        chk("leds_pwm", int'(leds_pwm), m_lpwm);
        chk("pending", int'(pending), int'(m_pend));
        chk("bad_addr", int'(bad_addr), int'(m_bad));
    endtask

    initial begin
        int grants[4];
        model_reset();

        // 1: reset, idle ticks
        step(1, 0); step(1, 0);
        repeat (3) step(0, 1);
        chk("idle leds1", int'(leds1), 0);
        chk("idle leds4", int'(leds4), 0);
        chk("idle pwm", int'(leds_pwm), 7);
        chk("idle pending", int'(pending), 0);

        // 2: single write then commit
        q0.push_back('{a: 3'd1, d: 8'hA5});
        step(0, 0);
        chk("A5 grant", last_grant, 0);
        chk("A5 pending", int'(pending), 1);
        chk("A5 pre-tick leds2", int'(leds2), 0);
        step(0, 0);
        chk("A5 still hidden", int'(leds2), 0);
        step(0, 1);
        chk("A5 leds2", int'(leds2), 8'hA5);
        chk("A5 pending clr", int'(pending), 0);

        // 3: contention alternates
        step(1, 0);
        q0.push_back('{a: 3'd0, d: 8'h11}); q0.push_back('{a: 3'd0, d: 8'h22});
        q1.push_back('{a: 3'd3, d: 8'h33}); q1.push_back('{a: 3'd3, d: 8'h44});
        for (int i = 0; i < 4; i++) begin
            step(0, 0);
            grants[i] = last_grant;
        end
        chk("rr g0", grants[0], 0);
        chk("rr g1", grants[1], 1);
        chk("rr g2", grants[2], 0);
        chk("rr g3", grants[3], 1);
        step(0, 1);
        chk("rr leds1", int'(leds1), 8'h22);
        chk("rr leds4", int'(leds4), 8'h44);

        // 4: write in the tick cycle misses that commit
        q0.push_back('{a: 3'd2, d: 8'h5A});
        step(0, 1);
        chk("tick-write leds3", int'(leds3), 0);
        chk("tick-write pending", int'(pending), 1);
        step(0, 1);
        chk("next-tick leds3", int'(leds3), 8'h5A);

        // 5: PWM write, then invalid address
        q1.push_back('{a: 3'd4, d: 8'hF2}); q1.push_back('{a: 3'd6, d: 8'hFF});
        step(0, 0);
        chk("pwm bad_addr", int'(bad_addr), 0);
        step(0, 0);
        chk("bad pulse", int'(bad_addr), 1);
        step(0, 0);
        chk("bad one-shot", int'(bad_addr), 0);
        step(0, 1);
        chk("pwm live", int'(leds_pwm), 2);
        chk("cols kept leds1", int'(leds1), 8'h22);

        // 6: reset discards a pending write
        q0.push_back('{a: 3'd0, d: 8'hC3});
        step(0, 0);
        step(1, 0);
        chk("rst leds1", int'(leds1), 0);
        chk("rst leds3", int'(leds3), 0);
        chk("rst pwm", int'(leds_pwm), 7);
        chk("rst pending", int'(pending), 0);
        step(0, 1);
        chk("post-rst tick leds1", int'(leds1), 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (q0.size() == 0 && $urandom_range(0, 2) != 0)
                q0.push_back('{a: 3'($urandom_range(0, 5)), d: 8'($urandom)});
            if (q1.size() == 0 && $urandom_range(0, 2) != 0)
                q1.push_back('{a: 3'($urandom_range(0, 7)), d: 8'($urandom)});
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
